// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns EX/MEM load/store requests into a single
// outstanding req/ack bus transaction, stalls the pipeline, and extends load data.
module dmem_access_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              memread_ex_mem,
   input  logic              memwrite_ex_mem,
   input  logic [2:0]        size_ex_mem,
   input  logic [ADDR_W-1:0] addr_ex_mem,
   input  logic [31:0]       wdata_ex_mem,
   output logic              mem_busy,
   output logic              rdata_valid,
   output logic [31:0]       rdata,
   output logic              misalign,
   output logic              bus_err,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t            state_q, state_d;
   logic [7:0]        cnt_q;
   logic [2:0]        size_q;
   logic [1:0]        off_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        be_q;
   logic [31:0]       wdata_q;
   logic              rdata_valid_q;
   logic              bus_err_q;
   logic [31:0]       rdata_q;

   logic              req_any;
   logic              misaligned;
   logic              start;
   logic              timed_out;
   logic              finish;
   logic [3:0]        be_d;
   logic [31:0]       wdata_d;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;
   logic [31:0]       load_ext;

   // ------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------
   assign req_any = memread_ex_mem | memwrite_ex_mem;

   // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
   always_comb begin
      misaligned = 1'b0;
      be_d       = 4'b1111;
      wdata_d    = wdata_ex_mem;
      unique case (size_ex_mem)
         3'b000, 3'b100: begin
            be_d    = 4'b0001 << addr_ex_mem[1:0];
            wdata_d = {4{wdata_ex_mem[7:0]}};
         end
         3'b001, 3'b101: begin
            misaligned = addr_ex_mem[0];
            be_d       = addr_ex_mem[1] ? 4'b1100 : 4'b0011;
            wdata_d    = {2{wdata_ex_mem[15:0]}};
         end
         default: misaligned = (addr_ex_mem[1:0] != 2'b00);
      endcase
      if (!memwrite_ex_mem) be_d = 4'b1111;
   end

   // Gated with rst_n so the combinational stall and pulse drop with reset too.
   assign start    = rst_n & (state_q == S_IDLE) & req_any & ~misaligned;
   assign misalign = rst_n & (state_q == S_IDLE) & req_any & misaligned;

   assign timed_out = (state_q == S_REQ) & ~bus_ack & (cnt_q == TIMEOUT_CNT);
   assign finish    = (state_q == S_REQ) & (bus_ack | timed_out);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_REQ;
         S_REQ:   if (finish) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_REQ && !bus_ack) cnt_q <= cnt_q + 8'd1;
         else if (state_q == S_IDLE)       cnt_q <= '0;
      end
   end

   // ------------------------------------------------------------------
   // Latched transaction fields
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         size_q  <= '0;
         off_q   <= '0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
      end else if (start) begin
         we_q    <= memwrite_ex_mem;
         size_q  <= size_ex_mem;
         off_q   <= addr_ex_mem[1:0];
         addr_q  <= {addr_ex_mem[ADDR_W-1:2], 2'b00};
         be_q    <= be_d;
         wdata_q <= wdata_d;
      end
   end

   // ------------------------------------------------------------------
   // Load extraction
   // ------------------------------------------------------------------
   always_comb begin
      lane_b   = bus_rdata[7:0];
      lane_h   = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      load_ext = bus_rdata;
      unique case (off_q)
         2'd0: lane_b = bus_rdata[7:0];
         2'd1: lane_b = bus_rdata[15:8];
         2'd2: lane_b = bus_rdata[23:16];
         2'd3: lane_b = bus_rdata[31:24];
         default: lane_b = bus_rdata[7:0];
      endcase
      unique case (size_q)
         3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
         3'b100:  load_ext = {24'd0, lane_b};
         3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
         3'b101:  load_ext = {16'd0, lane_h};
         default: load_ext = bus_rdata;
      endcase
   end

   // Completion flags are registered on the REQ->DONE edge, so they are high exactly in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_valid_q <= 1'b0;
         bus_err_q     <= 1'b0;
         rdata_q       <= '0;
      end else begin
         rdata_valid_q <= finish & ~we_q;
         bus_err_q     <= timed_out;
         if (finish && !we_q) rdata_q <= timed_out ? 32'd0 : load_ext;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus_req     = (state_q == S_REQ);
   assign mem_busy    = start | bus_req;
   assign bus_we      = we_q;
   assign bus_addr    = addr_q;
   assign bus_be      = be_q;
   assign bus_wdata   = wdata_q;
   assign rdata_valid = rdata_valid_q;
   assign bus_err     = bus_err_q;
   assign rdata       = rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed cases from the test plan plus
// randomized accesses checked against an arithmetic reference model.
module tb_dmem_access_ctrl;

   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              memread_ex_mem, memwrite_ex_mem;
   logic [2:0]        size_ex_mem;
   logic [ADDR_W-1:0] addr_ex_mem;
   logic [31:0]       wdata_ex_mem;
   logic              mem_busy, rdata_valid, misalign, bus_err;
   logic [31:0]       rdata;
   logic              bus_req, bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [3:0]        bus_be;
   logic [31:0]       bus_wdata;
   logic              bus_ack;
   logic [31:0]       bus_rdata;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_rdata = 32'd0;

   always #5 clk = ~clk;

   dmem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .memread_ex_mem(memread_ex_mem), .memwrite_ex_mem(memwrite_ex_mem),
      .size_ex_mem(size_ex_mem), .addr_ex_mem(addr_ex_mem), .wdata_ex_mem(wdata_ex_mem),
      .mem_busy(mem_busy), .rdata_valid(rdata_valid), .rdata(rdata),
      .misalign(misalign), .bus_err(bus_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int width_bytes(input logic [2:0] sz);
      case (sz)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         default:        return 4;
      endcase
   endfunction

   function automatic bit model_misaligned(input logic [2:0] sz, input logic [31:0] a);
      return (a % width_bytes(sz)) != 0;
   endfunction

   function automatic logic [3:0] model_be(input bit wr, input logic [2:0] sz, input logic [31:0] a);
      int w = width_bytes(sz);
      if (!wr || w == 4) return 4'hF;
      if (w == 1) return 4'(1 << (a % 4));
      return 4'(3 << (a % 4));
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] sz, input logic [31:0] d);
      int w = width_bytes(sz);
      if (w == 1) return (d & 32'hFF) * 32'h0101_0101;
      if (w == 2) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [31:0] a,
                                              input logic [31:0] word);
      int          w = width_bytes(sz);
      logic [31:0] v = word >> ((a % 4) * 8);
      logic [31:0] mask;
      bit          sgn;
      if (w == 4) return word;
      mask = (w == 1) ? 32'hFF : 32'hFFFF;
      sgn  = (sz == 3'b000 || sz == 3'b001);
      v    = v & mask;
      if (sgn && (v & ((mask + 1) >> 1)) != 0) v = v | ~mask;
      return v;
   endfunction

   // ---------------- one access, checked cycle by cycle ----------------
   // ack_dly = number of REQ cycles without ack before the acking one; > TIMEOUT means never.
   task automatic do_access(input bit rd, input bit wr, input logic [2:0] sz,
                            input logic [31:0] a, input logic [31:0] d,
                            input int ack_dly, input logic [31:0] word);
      bit to;
      int nreq;
      @(posedge clk); #1;
      memread_ex_mem = rd; memwrite_ex_mem = wr; size_ex_mem = sz;
      addr_ex_mem = a; wdata_ex_mem = d; bus_ack = 1'b0;
      @(negedge clk);
      check("idle_rvalid", rdata_valid, 0);
      check("idle_err", bus_err, 0);
      if (model_misaligned(sz, a)) begin
         check("misalign", misalign, 1);
         check("mis_busy", mem_busy, 0);
         check("mis_req", bus_req, 0);
         @(posedge clk); #1;
         memread_ex_mem = 1'b0; memwrite_ex_mem = 1'b0;
         @(negedge clk);
         check("mis_after", misalign, 0);
         check("mis_req2", bus_req, 0);
         check("mis_rdata", rdata, exp_rdata);
         return;
      end
      check("start_busy", mem_busy, 1);
      check("start_mis", misalign, 0);
      check("start_req", bus_req, 0);
      to   = (ack_dly > TIMEOUT);
      nreq = to ? TIMEOUT + 1 : ack_dly + 1;
      for (int i = 0; i < nreq; i++) begin
         @(posedge clk); #1;
         bus_ack   = (!to && i == ack_dly);
         bus_rdata = bus_ack ? word : $urandom;
         @(negedge clk);
         check("req", bus_req, 1);
         check("req_busy", mem_busy, 1);
         check("req_rvalid", rdata_valid, 0);
         if (i == 0) begin
            check("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
            check("bus_we", bus_we, wr);
            check("bus_be", bus_be, model_be(wr, sz, a));
            if (wr) check("bus_wdata", bus_wdata, model_wdata(sz, d));
         end
      end
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_rdata = $urandom;
      @(negedge clk);
      if (!wr) exp_rdata = to ? 32'd0 : model_load(sz, a, word);
      check("done_busy", mem_busy, 0);
      check("done_req", bus_req, 0);
      check("done_rvalid", rdata_valid, !wr);
      check("done_err", bus_err, to);
      check("done_rdata", rdata, exp_rdata);
      @(posedge clk); #1;
      memread_ex_mem = 1'b0; memwrite_ex_mem = 1'b0;
      bus_ack = 1'($urandom % 2);   // stray ack in IDLE must be ignored
      @(negedge clk);
      check("post_rvalid", rdata_valid, 0);
      check("post_err", bus_err, 0);
      check("post_busy", mem_busy, 0);
      check("post_req", bus_req, 0);
      check("post_rdata", rdata, exp_rdata);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      memread_ex_mem = 0; memwrite_ex_mem = 0; size_ex_mem = 0;
      addr_ex_mem = 0; wdata_ex_mem = 0; bus_ack = 0; bus_rdata = 0;
      #3;
      check("rst_busy", mem_busy, 0);
      check("rst_req", bus_req, 0);
      check("rst_rdata", rdata, 0);
      check("rst_rvalid", rdata_valid, 0);
      check("rst_be", bus_be, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Directed cases
      do_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);   // lw
      do_access(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_0000);  // lb
      do_access(1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF_0000);  // lbu
      do_access(1, 0, 3'b001, 32'h102, 32'h0, 1, 32'h80FF_0000);  // lh
      do_access(0, 1, 3'b000, 32'h201, 32'hA5, 3, 32'h0);         // sb
      do_access(1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h0);          // misaligned lw
      do_access(0, 1, 3'b001, 32'h001, 32'h1234, 0, 32'h0);       // misaligned sh
      do_access(1, 0, 3'b010, 32'h104, 32'h0, 100, 32'h0);        // timeout
      do_access(1, 0, 3'b101, 32'h106, 32'h0, TIMEOUT, 32'h9876_5432); // ack on last cycle
      do_access(1, 1, 3'b001, 32'h10A, 32'hCAFE_BABE, 2, 32'h0);  // read+write -> store

      // Reset in the second REQ cycle
      @(posedge clk); #1;
      memread_ex_mem = 1; size_ex_mem = 3'b010; addr_ex_mem = 32'h300; bus_ack = 0;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check("rq2_req", bus_req, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_req", bus_req, 0);
      check("arst_busy", mem_busy, 0);
      memread_ex_mem = 0;
      @(posedge clk); #1;
      rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
      exp_rdata = 32'd0;
      @(negedge clk);
      check("late_req", bus_req, 0);
      @(posedge clk); #1;
      bus_ack = 1'b0;
      @(negedge clk);
      check("late_rvalid", rdata_valid, 0);
      check("late_err", bus_err, 0);
      check("late_rdata", rdata, 0);
      do_access(1, 0, 3'b010, 32'h300, 32'h0, 0, 32'h0BAD_F00D);

      // Randomized accesses
      for (int n = 0; n < 60; n++) begin
         logic [2:0]  sz;
         logic [31:0] a;
         bit          rd, wr;
         int          dly;
         int          kind;
         sz   = 3'($urandom_range(0, 7));
         a    = $urandom & 32'h0000_FFFF;
         kind = $urandom_range(0, 3);
         rd   = (kind != 1);
         wr   = (kind == 1) || (kind == 3);
         dly  = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(0, 5);
         do_access(rd, wr, sz, a, $urandom, dly, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Responder side of the pipeline memory-stall protocol. Accepts load/store requests from the EX/MEM stage and runs a single-outstanding transaction on a req/ack data-memory bus. Drives mem_busy back to the pipeline for the whole access and returns aligned, sign-extended load data. Sits between the EX/MEM pipeline register and the data SRAM / MMIO bus.

Parameters:
ADDR_W, 32, byte address width
TIMEOUT, 15, max cycles bus_req may wait for bus_ack before bus error (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
memread_ex_mem  in  1  load request, level, held while mem_busy
memwrite_ex_mem  in  1  store request, level, held while mem_busy
size_ex_mem  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
addr_ex_mem  in  ADDR_W  byte address
wdata_ex_mem  in  32  store data (low bits used for b/h)
mem_busy  out  1  stall request to pipeline
rdata_valid  out  1  one-cycle pulse, load data valid
rdata  out  32  extended load data, held until next load completes
misalign  out  1  one-cycle pulse, misaligned access rejected
bus_err  out  1  one-cycle pulse, access timed out
bus_req  out  1  bus request
bus_we  out  1  1 = write
bus_addr  out  ADDR_W  word-aligned address (addr[1:0] forced 00)
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  bus completion
bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- Reset (async): state IDLE; all outputs 0, including rdata; timeout counter 0. Reset mid-access drops bus_req immediately; no completion pulse follows.
- start = IDLE & (memread | memwrite) & ~misaligned. If both read and write are asserted, write wins and it is treated as a store.
- Misaligned: h/hu with addr[0]=1; w with addr[1:0]!=0. In IDLE, misalign pulses for 1 cycle, there is no bus activity, and mem_busy stays 0. Unused funct3 codes are treated as w.
- FSM IDLE -> REQ -> DONE -> IDLE:
  - IDLE: on start, latch we/size/addr[1:0]/bus fields and go to REQ.
  - REQ: bus_req=1. bus_addr, bus_we, bus_be and bus_wdata are stable and latched. The counter increments each cycle without ack. bus_ack=1 completes the access, with ack sampled in any REQ cycle including the first. Counter == TIMEOUT without ack sets bus_err and goes to DONE.
  - DONE: one cycle. On a load with ack, rdata_valid=1 and rdata is updated. On timeout, bus_err=1, rdata is forced to 0 and rdata_valid=1 for loads. Then go to IDLE. A new start is not accepted in DONE.
- mem_busy = start (combinational in IDLE) | (state==REQ). It is 0 in DONE so the pipeline advances exactly once.
- Minimum latency: request cycle 0, bus_req cycle 1, ack cycle 1 gives DONE in cycle 2. mem_busy is high for exactly 2 cycles, matching the pipeline's 2-cycle memory stall.
- bus_ack outside REQ is ignored.
- Byte enables:
  - b: be = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - h: be = addr[1]?1100:0011, wdata = {2{wdata[15:0]}}.
  - w: be = 1111.
  - Reads drive be = 1111.
- Load extract: select the byte/half by latched addr[1:0]. b/h sign-extend; bu/hu zero-extend.

Test Plan:
- lw addr 0x100, bus_ack in first REQ cycle, bus_rdata 0xDEADBEEF -> mem_busy high 2 cycles; rdata_valid pulse in cycle 2; rdata=0xDEADBEEF; bus_be=1111.
- lb addr 0x103, rdata word 0x80FF_0000 -> rdata=0xFFFFFF80. lbu, same stimulus -> 0x00000080. lh addr 0x102 -> 0xFFFF80FF.
- sb addr 0x201, wdata 0x000000A5 -> bus_we=1, bus_be=0010, bus_wdata=0xA5A5A5A5, bus_addr=0x200; ack delayed 3 cycles -> mem_busy high 5 cycles; no rdata_valid.
- lw addr 0x102 -> misalign 1-cycle pulse, bus_req never asserted, mem_busy 0. sh addr 0x001 -> same.
- lw with bus_ack held 0, TIMEOUT=15 -> bus_req high 16 cycles, then bus_err and rdata_valid pulse with rdata=0, state back to IDLE.
- Assert rst_n=0 in the second REQ cycle -> bus_req and mem_busy fall asynchronously. A late bus_ack after reset release produces no pulse. A subsequent lw completes normally.
